// File: rtl/z_core_reg_writeback.sv
// Writeback queue between the ALU/load units and the register file write port.
// Ports: clk, reset (async active-low); alu_*/mem_* valid/ready result inputs;
// rf_hold and rf_* drive the reg file write port; fwd_* give rs1/rs2 bypass
// from pending entries; count reports queue occupancy.
module z_core_reg_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [4:0]                 mem_rd,
    input  logic [XLEN-1:0]            mem_data,
    input  logic                       rf_hold,
    output logic                       rf_write_enable,
    output logic [4:0]                 rf_rd,
    output logic [XLEN-1:0]            rf_rd_in,
    input  logic [4:0]                 fwd_rs1,
    input  logic [4:0]                 fwd_rs2,
    output logic                       fwd_rs1_hit,
    output logic [XLEN-1:0]            fwd_rs1_data,
    output logic                       fwd_rs2_hit,
    output logic [XLEN-1:0]            fwd_rs2_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    grant_e          last_q, last_d;

    logic            grant_mem;
    logic            grant_alu;
    logic            space;
    logic            accept;
    logic            push;
    logic            pop;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    // Mem wins a tie unless it was the last source accepted.
    assign grant_mem = mem_valid && (!alu_valid || last_q == GRANT_ALU);
    assign grant_alu = alu_valid && !grant_mem;

    assign pop   = (count_q != '0) && !rf_hold;
    assign space = (count_q < CW'(DEPTH)) || pop;

    // Readies forced low while reset is asserted, even before the edge.
    assign alu_ready = reset && grant_alu && space;
    assign mem_ready = reset && grant_mem && space;

    assign accept   = (alu_valid && alu_ready) || (mem_valid && mem_ready);
    assign sel_rd   = grant_mem ? mem_rd : alu_rd;
    assign sel_data = grant_mem ? mem_data : alu_data;
    // Writes to x0 complete the handshake but are dropped.
    assign push     = accept && (sel_rd != 5'd0);

    assign rf_write_enable = pop;
    assign rf_rd           = pop ? rd_q[head_q] : 5'd0;
    assign rf_rd_in        = pop ? data_q[head_q] : '0;
    assign count           = count_q;

    always_comb begin
        head_d  = pop ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        last_d  = last_q;
        if (accept) begin
            last_d = grant_mem ? GRANT_MEM : GRANT_ALU;
        end
    end

    // Scan oldest to youngest so the youngest match wins.
    function automatic logic [XLEN:0] lookup(input logic [4:0] rs);
        logic [XLEN:0] r;
        logic [PW-1:0] idx;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (rs != 5'd0 && CW'(i) < count_q && rd_q[idx] == rs) begin
                r = {1'b1, data_q[idx]};
            end
        end
        return r;
    endfunction

    always_comb begin
        {fwd_rs1_hit, fwd_rs1_data} = lookup(fwd_rs1);
        {fwd_rs2_hit, fwd_rs2_data} = lookup(fwd_rs2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            last_q  <= GRANT_ALU;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= 5'd0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            last_q  <= last_d;
            if (push) begin
                rd_q[tail_q]   <= sel_rd;
                data_q[tail_q] <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_z_core_reg_writeback.sv
// Directed bench for the writeback queue: arbitration, drain order,
// hold/full behaviour, x0 discard, forwarding and async reset.
module tb_z_core_reg_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        rf_hold;
    logic        rf_write_enable;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_in;
    logic [4:0]  fwd_rs1, fwd_rs2;
    logic        fwd_rs1_hit, fwd_rs2_hit;
    logic [31:0] fwd_rs1_data, fwd_rs2_data;
    logic [1:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    z_core_reg_writeback #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .rf_hold(rf_hold), .rf_write_enable(rf_write_enable),
        .rf_rd(rf_rd), .rf_rd_in(rf_rd_in),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs1_data(fwd_rs1_data),
        .fwd_rs2_hit(fwd_rs2_hit), .fwd_rs2_data(fwd_rs2_data),
        .count(count)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd,
                       input logic [31:0] d);
        alu_valid = v; alu_rd = rd; alu_data = d;
    endtask

    task automatic mem(input logic v, input logic [4:0] rd,
                       input logic [31:0] d);
        mem_valid = v; mem_rd = rd; mem_data = d;
    endtask

    task automatic wr(input string tag, input logic en,
                      input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_we"}, 64'(rf_write_enable), 64'(en));
        chk({tag, "_rd"}, 64'(rf_rd), 64'(rd));
        chk({tag, "_din"}, 64'(rf_rd_in), 64'(d));
    endtask

    initial begin
        reset = 1'b0;
        rf_hold = 1'b0;
        fwd_rs1 = 5'd0;
        fwd_rs2 = 5'd0;
        alu(1'b1, 5'd1, 32'd1);
        mem(1'b0, 5'd0, 32'd0);
        #2;
        chk("rst_cnt", 64'(count), 64'd0);
        chk("rst_ardy", 64'(alu_ready), 64'd0);
        chk("rst_mrdy", 64'(mem_ready), 64'd0);
        wr("rst", 1'b0, 5'd0, 32'd0);
        alu(1'b0, 5'd0, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // 1: single ALU write
        alu(1'b1, 5'd5, 32'd15);
        settle();
        chk("t1_ardy", 64'(alu_ready), 64'd1);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        settle();
        chk("t1_cnt", 64'(count), 64'd1);
        wr("t1", 1'b1, 5'd5, 32'd15);
        tick();
        settle();
        wr("t1_after", 1'b0, 5'd0, 32'd0);
        chk("t1_cnt0", 64'(count), 64'd0);
        tick();

        // 2: simultaneous, mem first
        alu(1'b1, 5'd8, 32'd25);
        mem(1'b1, 5'd9, 32'd99);
        settle();
        chk("t2_mrdy", 64'(mem_ready), 64'd1);
        chk("t2_ardy", 64'(alu_ready), 64'd0);
        tick();
        mem(1'b0, 5'd0, 32'd0);
        settle();
        chk("t2_ardy2", 64'(alu_ready), 64'd1);
        wr("t2_w9", 1'b1, 5'd9, 32'd99);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        settle();
        wr("t2_w8", 1'b1, 5'd8, 32'd25);
        tick();
        settle();
        chk("t2_cnt0", 64'(count), 64'd0);
        tick();

        // 3: full under hold
        rf_hold = 1'b1;
        alu(1'b1, 5'd3, 32'd1);
        tick();
        alu(1'b1, 5'd4, 32'd2);
        tick();
        alu(1'b1, 5'd6, 32'd3);
        mem(1'b1, 5'd12, 32'd77);
        fwd_rs1 = 5'd4;
        fwd_rs2 = 5'd3;
        settle();
        chk("t3_cnt2", 64'(count), 64'd2);
        chk("t3_ardy0", 64'(alu_ready), 64'd0);
        chk("t3_mrdy0", 64'(mem_ready), 64'd0);
        chk("t3_h1", 64'(fwd_rs1_hit), 64'd1);
        chk("t3_d1", 64'(fwd_rs1_data), 64'd2);
        chk("t3_h2", 64'(fwd_rs2_hit), 64'd1);
        chk("t3_d2", 64'(fwd_rs2_data), 64'd1);
        wr("t3_hold", 1'b0, 5'd0, 32'd0);
        mem(1'b0, 5'd0, 32'd0);
        rf_hold = 1'b0;
        settle();
        chk("t3_ardy1", 64'(alu_ready), 64'd1);
        wr("t3_w3", 1'b1, 5'd3, 32'd1);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        settle();
        chk("t3_cntf", 64'(count), 64'd2);
        wr("t3_w4", 1'b1, 5'd4, 32'd2);
        tick();
        settle();
        wr("t3_w6", 1'b1, 5'd6, 32'd3);
        tick();
        settle();
        chk("t3_cnt0", 64'(count), 64'd0);

        // 4: x0 discarded
        alu(1'b1, 5'd0, 32'd40);
        fwd_rs1 = 5'd0;
        settle();
        chk("t4_ardy", 64'(alu_ready), 64'd1);
        chk("t4_h", 64'(fwd_rs1_hit), 64'd0);
        chk("t4_d", 64'(fwd_rs1_data), 64'd0);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        settle();
        chk("t4_cnt", 64'(count), 64'd0);
        chk("t4_we", 64'(rf_write_enable), 64'd0);
        tick();

        // 5: duplicate rd, youngest forwarded
        rf_hold = 1'b1;
        alu(1'b1, 5'd7, 32'd10);
        tick();
        alu(1'b1, 5'd7, 32'd20);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        fwd_rs2 = 5'd7;
        settle();
        chk("t5_h", 64'(fwd_rs2_hit), 64'd1);
        chk("t5_d", 64'(fwd_rs2_data), 64'd20);
        rf_hold = 1'b0;
        settle();
        wr("t5_w10", 1'b1, 5'd7, 32'd10);
        tick();
        settle();
        wr("t5_w20", 1'b1, 5'd7, 32'd20);
        chk("t5_d2", 64'(fwd_rs2_data), 64'd20);
        tick();
        settle();
        chk("t5_cnt0", 64'(count), 64'd0);
        chk("t5_h0", 64'(fwd_rs2_hit), 64'd0);

        // 6: async reset with queued entries
        rf_hold = 1'b1;
        alu(1'b1, 5'd1, 32'd11);
        tick();
        alu(1'b1, 5'd2, 32'd22);
        tick();
        fwd_rs1 = 5'd1;
        settle();
        chk("t6_cnt2", 64'(count), 64'd2);
        reset = 1'b0;
        #1;
        chk("t6_cnt", 64'(count), 64'd0);
        chk("t6_ardy", 64'(alu_ready), 64'd0);
        chk("t6_h", 64'(fwd_rs1_hit), 64'd0);
        chk("t6_d", 64'(fwd_rs1_data), 64'd0);
        wr("t6_rst", 1'b0, 5'd0, 32'd0);
        alu(1'b0, 5'd0, 32'd0);
        rf_hold = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t6_nowr", 64'(rf_write_enable), 64'd0);
            chk("t6_cnt0", 64'(count), 64'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
